// File: rtl/if_pkg.sv
// if_pkg: shared defaults, entry type and pointer-width constant for the fetch queue.
package if_pkg;
    localparam int IF_PC_W    = 32;
    localparam int IF_INSTR_W = 32;
    localparam int IF_DEPTH   = 4;
    localparam int IF_PC_STEP = 4;
    localparam int IF_PTR_W   = $clog2(IF_DEPTH);

    typedef struct packed {
        logic [IF_PC_W-1:0]    pc;
        logic [IF_INSTR_W-1:0] instr;
    } if_entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: generic synchronous circular FIFO; flush beats push and pop.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int W     = $bits(if_entry_t),
    parameter int DEPTH = IF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_count;
    assign o_full  = r_count == (PTR_W+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_mem[r_wr] <= i_data;
            r_wr    <= r_wr + PTR_W'(w_push);
            r_rd    <= r_rd + PTR_W'(w_pop);
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC owner and fetch queue feeding decode over valid/ready.
// Define IF_FETCH_QUEUE_PERF_EN to add perf_fetch_cnt / perf_stall_cnt.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int               PC_W     = IF_PC_W,
    parameter int               INSTR_W  = IF_INSTR_W,
    parameter int               DEPTH    = IF_DEPTH,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int               PC_STEP  = IF_PC_STEP
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef IF_FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    localparam int W = PC_W + INSTR_W;

    logic [PC_W-1:0]        r_pc;
    logic [W-1:0]           w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_unused_count;

    assign imem_addr      = r_pc;
    assign out_valid      = !w_empty;
    assign out_pc         = w_head[W-1:INSTR_W];
    assign out_instr      = w_head[INSTR_W-1:0];
    assign w_pop          = out_valid && out_ready && !redirect_valid;
    assign w_push         = !redirect_valid && (!w_full || w_pop);
    assign w_unused_count = ^w_count;

    if_fetch_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_pc, imem_data}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_pc <= RESET_PC;
        else if (redirect_valid) r_pc <= redirect_pc;
        else if (w_push) r_pc <= r_pc + PC_W'(PC_STEP);
    end

`ifdef IF_FETCH_QUEUE_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + 32'(w_push);
            r_stall_cnt <= r_stall_cnt + 32'(out_valid && !out_ready);
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed checks of fetch order, backpressure, redirect and reset.
module tb_if_fetch_queue;
    import if_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef IF_FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_chk;
    int n_pass;

    if_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef IF_FETCH_QUEUE_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_data = instr_of(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_addr", imem_addr, 0);

        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_pc", out_pc, 32'(4 * i));
            chk("stream_instr", out_instr, instr_of(32'(4 * i)));
        end

        do_reset();
        out_ready = 1'b0;
        repeat (10) step();
        chk("bp_addr", imem_addr, 16);
        chk("bp_valid", 32'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            chk("drain_pc", out_pc, 32'(4 * i));
            chk("drain_instr", out_instr, instr_of(32'(4 * i)));
            chk("full_addr", imem_addr, 32'(4 * i + 16));
            out_ready = 1'b1;
            step();
        end

        do_reset();
        out_ready = 1'b0;
        repeat (3) step();
        chk("three_addr", imem_addr, 12);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        out_ready = 1'b1;
        step();
        chk("redir_valid", 32'(out_valid), 0);
        chk("redir_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0;
        step();
        chk("redir_head_valid", 32'(out_valid), 1);
        chk("redir_head_pc", out_pc, 32'h100);
        chk("redir_head_instr", out_instr, instr_of(32'h100));

        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_pc = 32'h300;
        step();
        chk("b2b_valid", 32'(out_valid), 0);
        chk("b2b_addr", imem_addr, 32'h300);
        redirect_valid = 1'b0;
        step();
        chk("b2b_pc", out_pc, 32'h300);
        step();
        chk("b2b_next_pc", out_pc, 32'h304);

        out_ready = 1'b0;
        repeat (5) step();
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        step();
        chk("rstredir_valid", 32'(out_valid), 0);
        chk("rstredir_addr", imem_addr, 0);
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        chk("rstredir_head_valid", 32'(out_valid), 1);
        chk("rstredir_head_pc", out_pc, 0);

`ifdef IF_FETCH_QUEUE_PERF_EN
        out_ready = 1'b0;
        do_reset();
        chk("perf_rst_fetch", perf_fetch_cnt, 0);
        chk("perf_rst_stall", perf_stall_cnt, 0);
        repeat (6) step();
        out_ready = 1'b1;
        repeat (4) step();
        chk("perf_fetch", perf_fetch_cnt, 8);
        chk("perf_stall", perf_stall_cnt, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
